// File: rtl/arp_reply_ctrl.sv
// Purpose: gates ARP bytes into the field decoder, checks decoded requests for the local IP and streams a 28-byte ARP reply.
// Latency: evaluation one cycle after the last request byte; tx_req the cycle after that; the first reply byte appears the cycle after tx_grant.
// Backpressure: reply bytes hold while tx_ready=0; rx has no backpressure, and frames arriving while busy are counted and discarded.
module arp_reply_ctrl #(
    parameter int ARP_LEN     = 28,
    parameter int GNT_TIMEOUT = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             sync_reset_n,
    input  logic [47:0]      local_mac,
    input  logic [31:0]      local_ip,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             rx_sof,
    input  logic             rx_eof,
    output logic             dec_clear,
    output logic [7:0]       dec_data,
    output logic             dec_data_valid,
    input  logic             dec_fields_ok,
    input  logic [15:0]      dec_operation,
    input  logic [47:0]      dec_sha,
    input  logic [31:0]      dec_spa,
    input  logic [31:0]      dec_tpa,
    output logic             tx_req,
    input  logic             tx_grant,
    output logic [47:0]      tx_dst_mac,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_last,
    output logic [CNT_W-1:0] replies_sent,
    output logic [CNT_W-1:0] frames_dropped
);

    localparam int BC_W = $clog2(ARP_LEN + 1);
    localparam int TM_W = $clog2(GNT_TIMEOUT + 1);
    localparam int IX_W = $clog2(ARP_LEN);

    typedef enum logic [2:0] {IDLE, RX, EVAL, WAIT_GNT, TX} state_t;

    state_t            state_q, state_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d, cnt_nxt;
    logic [TM_W-1:0]   timer_q, timer_d;
    logic [IX_W-1:0]   idx_q, idx_d;
    logic [47:0]       tgt_mac_q;
    logic [31:0]       tgt_ip_q;
    logic [CNT_W-1:0]  replies_q, dropped_q;
    logic              capture, drop_frame, drop_tmo, busy_drop, sent, clr;
    logic              accept;
    logic [1:0]        drop_inc;
    logic [CNT_W:0]    drop_sum;
    logic [27:0][7:0]  reply_b;

    // Byte count for the current rx byte: restart on sof, otherwise saturate at the payload length.
    assign cnt_nxt = rx_sof ? BC_W'(1)
                   : (byte_cnt_q == BC_W'(ARP_LEN)) ? byte_cnt_q : byte_cnt_q + 1'b1;

    assign accept    = dec_fields_ok && (dec_operation == 16'h0001) && (dec_tpa == local_ip);
    assign busy_drop = rx_valid && rx_sof &&
                       (state_q == EVAL || state_q == WAIT_GNT || state_q == TX);

    // Reply payload, first byte in the highest slot.
    assign reply_b = {16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
                      local_mac, local_ip, tgt_mac_q, tgt_ip_q};

    // Next-state logic and per-cycle event strobes.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        timer_d    = timer_q;
        idx_d      = idx_q;
        capture    = 1'b0;
        drop_frame = 1'b0;
        drop_tmo   = 1'b0;
        sent       = 1'b0;
        clr        = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid && rx_sof) begin
                    if (rx_eof) begin
                        drop_frame = 1'b1;
                        clr        = 1'b1;
                    end else begin
                        byte_cnt_d = BC_W'(1);
                        state_d    = RX;
                    end
                end
            end
            RX: begin
                if (rx_valid) begin
                    byte_cnt_d = cnt_nxt;
                    if (rx_eof) begin
                        byte_cnt_d = '0;
                        if (cnt_nxt == BC_W'(ARP_LEN)) begin
                            state_d = EVAL;
                        end else begin
                            drop_frame = 1'b1;
                            clr        = 1'b1;
                            state_d    = IDLE;
                        end
                    end
                end
            end
            EVAL: begin
                clr = 1'b1;
                if (accept) begin
                    capture = 1'b1;
                    timer_d = '0;
                    state_d = WAIT_GNT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_GNT: begin
                if (tx_grant) begin
                    idx_d   = '0;
                    timer_d = '0;
                    state_d = TX;
                end else if (timer_q == TM_W'(GNT_TIMEOUT - 1)) begin
                    drop_tmo = 1'b1;
                    timer_d  = '0;
                    state_d  = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            TX: begin
                if (tx_ready) begin
                    if (idx_q == IX_W'(ARP_LEN - 1)) begin
                        sent    = 1'b1;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A busy sof and a grant timeout can land in the same cycle, so the drop counter may step by two.
    assign drop_inc = {1'b0, drop_frame | drop_tmo} + {1'b0, busy_drop};
    assign drop_sum = {1'b0, dropped_q} + (CNT_W + 1)'(drop_inc);

    // State, counters and captured requester address.
    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            timer_q    <= '0;
            idx_q      <= '0;
            tgt_mac_q  <= '0;
            tgt_ip_q   <= '0;
            replies_q  <= '0;
            dropped_q  <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            if (capture) begin
                tgt_mac_q <= dec_sha;
                tgt_ip_q  <= dec_spa;
            end
            if (sent && replies_q != '1) begin
                replies_q <= replies_q + 1'b1;
            end
            dropped_q <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

    // In IDLE only a sof byte reaches the decoder, so tails of discarded frames never pollute it.
    assign dec_data       = rx_data;
    assign dec_data_valid = sync_reset_n && rx_valid &&
                            ((state_q == IDLE && rx_sof) ||
                             (state_q == RX && byte_cnt_q < BC_W'(ARP_LEN)));
    assign dec_clear      = !sync_reset_n || clr;

    assign tx_req         = (state_q == WAIT_GNT) || (state_q == TX);
    assign tx_valid       = (state_q == TX);
    assign tx_last        = (state_q == TX) && (idx_q == IX_W'(ARP_LEN - 1));
    assign tx_data        = (state_q == TX) ? reply_b[IX_W'(ARP_LEN - 1) - idx_q] : 8'h00;
    assign tx_dst_mac     = tgt_mac_q;
    assign replies_sent   = replies_q;
    assign frames_dropped = dropped_q;

endmodule

// File: tb/tb_arp_reply_ctrl.sv
// Purpose: self-checking bench for arp_reply_ctrl with a behavioural decoder and a frame-level reference model.
// Latency: the model is stepped on each rising edge and compared on each falling edge.
// Backpressure: tx_grant and tx_ready are driven by configurable fixed, patterned or random policies.
module tb_arp_reply_ctrl;
    localparam int ARP_LEN     = 28;
    localparam int GNT_TIMEOUT = 8;
    localparam int CNT_W       = 16;

    logic             clk = 1'b0;
    logic             sync_reset_n;
    logic [47:0]      local_mac;
    logic [31:0]      local_ip;
    logic [7:0]       rx_data;
    logic             rx_valid, rx_sof, rx_eof;
    logic             dec_clear;
    logic [7:0]       dec_data;
    logic             dec_data_valid;
    logic             dec_fields_ok;
    logic [15:0]      dec_operation;
    logic [47:0]      dec_sha;
    logic [31:0]      dec_spa, dec_tpa;
    logic             tx_req, tx_grant;
    logic [47:0]      tx_dst_mac;
    logic [7:0]       tx_data;
    logic             tx_valid, tx_ready, tx_last;
    logic [CNT_W-1:0] replies_sent, frames_dropped;

    arp_reply_ctrl #(.ARP_LEN(ARP_LEN), .GNT_TIMEOUT(GNT_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .sync_reset_n(sync_reset_n), .local_mac(local_mac), .local_ip(local_ip),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
        .dec_clear(dec_clear), .dec_data(dec_data), .dec_data_valid(dec_data_valid),
        .dec_fields_ok(dec_fields_ok), .dec_operation(dec_operation), .dec_sha(dec_sha),
        .dec_spa(dec_spa), .dec_tpa(dec_tpa), .tx_req(tx_req), .tx_grant(tx_grant),
        .tx_dst_mac(tx_dst_mac), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_last(tx_last), .replies_sent(replies_sent), .frames_dropped(frames_dropped)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural field decoder: stores the first 28 forwarded bytes, cleared synchronously.
    bit [7:0] dbuf [28];
    int       dcnt = 0;
    always @(posedge clk) begin
        if (dec_clear) begin
            dcnt <= 0;
        end else if (dec_data_valid) begin
            if (dcnt < 28) dbuf[dcnt] <= dec_data;
            dcnt <= dcnt + 1;
        end
    end
    always_comb begin
        dec_fields_ok = (dcnt >= 28) && dbuf[0] == 8'h00 && dbuf[1] == 8'h01 && dbuf[2] == 8'h08 &&
                        dbuf[3] == 8'h00 && dbuf[4] == 8'h06 && dbuf[5] == 8'h04;
        dec_operation = {dbuf[6], dbuf[7]};
        dec_sha       = {dbuf[8], dbuf[9], dbuf[10], dbuf[11], dbuf[12], dbuf[13]};
        dec_spa       = {dbuf[14], dbuf[15], dbuf[16], dbuf[17]};
        dec_tpa       = {dbuf[24], dbuf[25], dbuf[26], dbuf[27]};
    end

    // Reference model: frame bytes seen, pending evaluation, grant wait, reply being sent.
    bit         m_in_frame = 1'b0;
    bit         m_eval     = 1'b0;
    int         m_wait     = -1;
    int         m_send     = -1;
    logic [7:0] m_fb[$];
    logic [7:0] m_reply [28];
    logic [47:0] m_dst = '0;
    int         m_sent = 0;
    int         m_drop = 0;

    function automatic bit m_idle();
        return !m_in_frame && !m_eval && m_wait < 0 && m_send < 0;
    endfunction

    task automatic model_eval();
        logic [31:0]  tpa;
        logic [223:0] v;
        tpa = {m_fb[24], m_fb[25], m_fb[26], m_fb[27]};
        if (m_fb[0] == 8'h00 && m_fb[1] == 8'h01 && m_fb[2] == 8'h08 && m_fb[3] == 8'h00 &&
            m_fb[4] == 8'h06 && m_fb[5] == 8'h04 && m_fb[6] == 8'h00 && m_fb[7] == 8'h01 &&
            tpa == local_ip) begin
            m_dst = {m_fb[8], m_fb[9], m_fb[10], m_fb[11], m_fb[12], m_fb[13]};
            v = {64'h0001080006040002, local_mac, local_ip, m_dst,
                 m_fb[14], m_fb[15], m_fb[16], m_fb[17]};
            for (int i = 0; i < 28; i++) m_reply[i] = v[223 - 8*i -: 8];
            m_wait = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!sync_reset_n) begin
                m_in_frame = 1'b0; m_eval = 1'b0; m_wait = -1; m_send = -1;
                m_fb.delete(); m_dst = '0; m_sent = 0; m_drop = 0;
            end else begin
                if ((m_eval || m_wait >= 0 || m_send >= 0) && rx_valid && rx_sof) m_drop++;
                if (m_in_frame) begin
                    if (rx_valid) begin
                        m_fb.push_back(rx_data);
                        if (rx_eof) begin
                            m_in_frame = 1'b0;
                            if (m_fb.size() >= ARP_LEN) m_eval = 1'b1;
                            else m_drop++;
                        end
                    end
                end else if (m_idle() && rx_valid && rx_sof) begin
                    m_fb.delete();
                    m_fb.push_back(rx_data);
                    if (rx_eof) m_drop++;
                    else m_in_frame = 1'b1;
                end else if (m_eval) begin
                    m_eval = 1'b0;
                    model_eval();
                end else if (m_wait >= 0) begin
                    if (tx_grant) begin
                        m_wait = -1; m_send = 0;
                    end else if (m_wait == GNT_TIMEOUT - 1) begin
                        m_wait = -1; m_drop++;
                    end else begin
                        m_wait++;
                    end
                end else if (m_send >= 0) begin
                    if (tx_ready) begin
                        if (m_send == ARP_LEN - 1) begin
                            m_send = -1; m_sent++;
                        end else begin
                            m_send++;
                        end
                    end
                end
            end
        end
    end

    // Observation statistics used by the directed literal checks.
    logic [7:0]  got[$];
    int          last_pos = -1;
    int          req_hi   = 0;
    int          clr_cnt  = 0;
    logic [47:0] seen_dst = '0;

    task automatic clear_obs();
        got.delete(); last_pos = -1; req_hi = 0; clr_cnt = 0; seen_dst = '0;
    endtask

    // Compare process: DUT outputs against the model on every falling edge.
    initial begin
        bit e_ddv, e_clr, e_req, idle;
        logic [7:0] e_data;
        @(posedge clk);
        forever begin
            @(negedge clk);
            idle   = m_idle();
            e_ddv  = sync_reset_n && rx_valid &&
                     ((idle && rx_sof) || (m_in_frame && m_fb.size() < ARP_LEN));
            e_clr  = !sync_reset_n || m_eval ||
                     (rx_valid && rx_eof && ((idle && rx_sof) || (m_in_frame && m_fb.size() + 1 < ARP_LEN)));
            e_req  = m_wait >= 0 || m_send >= 0;
            e_data = (m_send >= 0) ? m_reply[m_send] : 8'h00;
            check("dec_data_valid", 64'(dec_data_valid), 64'(e_ddv));
            check("dec_clear", 64'(dec_clear), 64'(e_clr));
            if (e_ddv) check("dec_data", 64'(dec_data), 64'(rx_data));
            check("tx_req", 64'(tx_req), 64'(e_req));
            check("tx_valid", 64'(tx_valid), 64'(m_send >= 0));
            check("tx_last", 64'(tx_last), 64'(m_send == ARP_LEN - 1));
            check("tx_data", 64'(tx_data), 64'(e_data));
            if (e_req) check("tx_dst_mac", 64'(tx_dst_mac), 64'(m_dst));
            check("replies_sent", 64'(replies_sent), 64'(m_sent));
            check("frames_dropped", 64'(frames_dropped), 64'(m_drop));
            if (tx_req && req_hi == 0) seen_dst = tx_dst_mac;
            if (tx_req) req_hi++;
            if (dec_clear && sync_reset_n) clr_cnt++;
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
                if (tx_last) last_pos = got.size() - 1;
            end
        end
    end

    // Arbiter / sink policies: 0 fixed, 1 delayed or patterned, 2 random, 3 stalled.
    int gnt_mode = 1, gnt_delay = 3, gnt_pct = 30;
    int rdy_mode = 0, rdy_pct = 70, rdy_step = 0;
    int req_cnt = 0;
    int rpat [4] = '{1, 0, 0, 1};
    initial begin
        tx_grant = 1'b0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (tx_req) req_cnt++; else req_cnt = 0;
            case (gnt_mode)
                1:       tx_grant = tx_req && (req_cnt == gnt_delay + 1);
                2:       tx_grant = tx_req && ($urandom_range(99) < gnt_pct);
                default: tx_grant = 1'b0;
            endcase
            case (rdy_mode)
                1: begin
                    tx_ready = rpat[rdy_step % 4] != 0;
                    if (tx_valid) rdy_step++;
                end
                2:       tx_ready = $urandom_range(99) < rdy_pct;
                3:       tx_ready = 1'b0;
                default: tx_ready = 1'b1;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] fq[$];

    task automatic build_req(input logic [15:0] op, input logic [47:0] sha, input logic [31:0] spa,
                             input logic [31:0] tpa, input int len);
        logic [223:0] v;
        v = {64'h0001080006040000 | 64'(op), sha, spa, 48'h0, tpa};
        fq.delete();
        for (int i = 0; i < 28; i++) fq.push_back(v[223 - 8*i -: 8]);
        while (fq.size() > len) void'(fq.pop_back());
        while (fq.size() < len) fq.push_back(8'($urandom));
    endtask

    task automatic send_fq();
        for (int i = 0; i < fq.size(); i++) begin
            rx_valid = 1'b1;
            rx_data  = fq[i];
            rx_sof   = (i == 0);
            rx_eof   = (i == fq.size() - 1);
            tick();
        end
        rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_data = 8'h00;
    endtask

    function automatic logic [63:0] got_word(input int start, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r = {r[55:0], got[start + i]};
        return r;
    endfunction

    initial begin
        logic [223:0] ev;
        int len, r;
        sync_reset_n = 1'b0;
        local_mac = 48'h02AABBCCDDEE;
        local_ip  = 32'hC0A80A02;
        rx_data = 8'h00; rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
        repeat (3) tick();
        sync_reset_n = 1'b1;
        tick();
        check("rst_replies", 64'(replies_sent), 64'd0);
        check("rst_dropped", 64'(frames_dropped), 64'd0);
        check("rst_tx_req", 64'(tx_req), 64'd0);

        // Valid request, grant 3 cycles after request, sink always ready.
        gnt_mode = 1; gnt_delay = 3; rdy_mode = 0;
        clear_obs();
        build_req(16'h0001, 48'h001122334455, 32'hC0A80A01, 32'hC0A80A02, 28);
        send_fq();
        for (int i = 0; i < 100 && replies_sent != 1; i++) tick();
        tick();
        check("t1_replies", 64'(replies_sent), 64'd1);
        check("t1_dst_mac", 64'(seen_dst), 64'h001122334455);
        check("t1_nbytes", 64'(got.size()), 64'd28);
        check("t1_last_pos", 64'(last_pos), 64'd27);
        check("t1_req_cycles", 64'(req_hi), 64'd32);
        if (got.size() == 28) begin
            check("t1_header", got_word(0, 8), 64'h0001080006040002);
            check("t1_sha", got_word(8, 6), 64'h02AABBCCDDEE);
            check("t1_tpa", got_word(24, 4), 64'hC0A80A01);
        end

        // Request for another IP: silently ignored, one decoder clear.
        clear_obs();
        build_req(16'h0001, 48'h001122334455, 32'hC0A80A01, 32'hC0A80A03, 28);
        send_fq();
        repeat (10) tick();
        check("t2_req_cycles", 64'(req_hi), 64'd0);
        check("t2_replies", 64'(replies_sent), 64'd1);
        check("t2_dropped", 64'(frames_dropped), 64'd0);
        check("t2_clears", 64'(clr_cnt), 64'd1);

        // Short frame ending at byte 20.
        clear_obs();
        build_req(16'h0001, 48'h001122334455, 32'hC0A80A01, 32'hC0A80A02, 20);
        send_fq();
        repeat (5) tick();
        check("t3_dropped", 64'(frames_dropped), 64'd1);
        check("t3_clears", 64'(clr_cnt), 64'd1);
        check("t3_req_cycles", 64'(req_hi), 64'd0);

        // No grant: request held exactly GNT_TIMEOUT cycles, then dropped.
        gnt_mode = 0;
        clear_obs();
        build_req(16'h0001, 48'h001122334455, 32'hC0A80A01, 32'hC0A80A02, 28);
        send_fq();
        repeat (20) tick();
        check("t4_req_cycles", 64'(req_hi), 64'd8);
        check("t4_dropped", 64'(frames_dropped), 64'd2);

        // Sink ready pattern 1,0,0,1 during transmission.
        gnt_mode = 1; gnt_delay = 0; rdy_step = 0; rdy_mode = 1;
        clear_obs();
        build_req(16'h0001, 48'h0A0B0C0D0E0F, 32'hC0A80A05, 32'hC0A80A02, 28);
        send_fq();
        for (int i = 0; i < 200 && replies_sent != 2; i++) tick();
        tick();
        check("t5_replies", 64'(replies_sent), 64'd2);
        check("t5_nbytes", 64'(got.size()), 64'd28);
        ev = {64'h0001080006040002, 48'h02AABBCCDDEE, 32'hC0A80A02, 48'h0A0B0C0D0E0F, 32'hC0A80A05};
        if (got.size() == 28) begin
            for (int i = 0; i < 28; i++) check($sformatf("t5_byte%0d", i), 64'(got[i]), 64'(ev[223 - 8*i -: 8]));
        end

        // Random traffic checked cycle by cycle against the model.
        gnt_mode = 2; gnt_pct = 30; rdy_mode = 2; rdy_pct = 70;
        for (int f = 0; f < 120; f++) begin
            r = $urandom_range(9);
            len = (r < 6) ? 28 : (r < 8) ? $urandom_range(27, 1) : $urandom_range(40, 29);
            build_req(($urandom_range(3) == 0) ? 16'h0002 : 16'h0001, {16'h0000, 32'($urandom)},
                      32'($urandom), ($urandom_range(2) == 0) ? 32'($urandom) : local_ip, len);
            if ($urandom_range(9) == 0 && fq.size() > 2) fq[2] = fq[2] ^ 8'h01;
            send_fq();
            repeat ($urandom_range(8)) tick();
        end
        repeat (60) tick();

        // Busy frame during a stalled reply, then reset mid-transmission.
        sync_reset_n = 1'b0;
        repeat (2) tick();
        sync_reset_n = 1'b1;
        tick();
        check("t6_rst_dropped", 64'(frames_dropped), 64'd0);
        check("t6_rst_replies", 64'(replies_sent), 64'd0);
        gnt_mode = 1; gnt_delay = 0; rdy_mode = 3;
        build_req(16'h0001, 48'h001122334455, 32'hC0A80A01, 32'hC0A80A02, 28);
        send_fq();
        for (int i = 0; i < 50 && !tx_valid; i++) tick();
        check("t6_in_tx", 64'(tx_valid), 64'd1);
        build_req(16'h0001, 48'h001122334466, 32'hC0A80A09, 32'hC0A80A02, 28);
        send_fq();
        check("t6_busy_dropped", 64'(frames_dropped), 64'd1);
        sync_reset_n = 1'b0;
        tick();
        check("t6_tx_valid", 64'(tx_valid), 64'd0);
        check("t6_tx_req", 64'(tx_req), 64'd0);
        check("t6_tx_last", 64'(tx_last), 64'd0);
        check("t6_tx_data", 64'(tx_data), 64'd0);
        check("t6_dst_mac", 64'(tx_dst_mac), 64'd0);
        check("t6_dropped", 64'(frames_dropped), 64'd0);
        check("t6_replies", 64'(replies_sent), 64'd0);
        check("t6_dec_clear_rst", 64'(dec_clear), 64'd1);
        tick();
        sync_reset_n = 1'b1;
        rdy_mode = 0;
        tick();
        check("t6_dec_clear", 64'(dec_clear), 64'd0);
        check("t6_dec_valid", 64'(dec_data_valid), 64'd0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, time %0t limit %0d", $time, 1000000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
